// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier controller.
package mult_pkg;

    localparam int MULT_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        TEST   = 3'd3,
        ADD    = 3'd4,
        SHIFT  = 3'd5,
        DONE   = 3'd6
    } mult_state_t;

endpackage

// File: rtl/mult_control.sv
// Moore controller for the N-bit shift-add multiplier data path.
// Drives every enable and mux select of the data path and runs the go/done handshake.
//   state  | meaning
//   IDLE   | waiting for go
//   LOAD   | load a_in/b_in, clear p, clear iteration count
//   SETTLE | wait one clock for the registered zero flag to follow b
//   TEST   | choose DONE, ADD or SHIFT
//   ADD    | p <= p + a
//   SHIFT  | a <<= 1, b >>= 1, count one iteration
//   DONE   | product valid; held until go drops
module mult_control
    import mult_pkg::*;
#(
    parameter int N = MULT_W
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic go_i,
    input  logic zero_i,
    input  logic lsb_b_i,
    output logic en_a_o,
    output logic ld_shift_a_o,
    output logic en_b_o,
    output logic ld_shift_b_o,
    output logic en_p_o,
    output logic ld_add_p_o,
    output logic busy_o,
    output logic done_o
);

    localparam int CW = $clog2(N + 1);

    mult_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:   if (go_i) state_d = LOAD;
            LOAD: begin
                cnt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: state_d = TEST;
            // The count limit only guards against a data path whose zero flag never rises.
            TEST: begin
                if (zero_i || (cnt_q == CW'(N))) state_d = DONE;
                else if (lsb_b_i)                state_d = ADD;
                else                             state_d = SHIFT;
            end
            ADD:    state_d = SHIFT;
            SHIFT: begin
                if (cnt_q != CW'(N)) cnt_d = cnt_q + CW'(1);
                state_d = SETTLE;
            end
            DONE:   if (!go_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        en_a_o       = 1'b0;
        ld_shift_a_o = 1'b0;
        en_b_o       = 1'b0;
        ld_shift_b_o = 1'b0;
        en_p_o       = 1'b0;
        ld_add_p_o   = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (state_q)
            LOAD: begin
                en_a_o = 1'b1;
                en_b_o = 1'b1;
                en_p_o = 1'b1;
                busy_o = 1'b1;
            end
            SETTLE, TEST: busy_o = 1'b1;
            ADD: begin
                en_p_o     = 1'b1;
                ld_add_p_o = 1'b1;
                busy_o     = 1'b1;
            end
            SHIFT: begin
                en_a_o       = 1'b1;
                ld_shift_a_o = 1'b1;
                en_b_o       = 1'b1;
                ld_shift_b_o = 1'b1;
                busy_o       = 1'b1;
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

endmodule
